// File: rtl/fp_div_if.sv
// Handshake bundle for the sequential floating-point divider.
// Operands go in on the in_* side, quotient and flags come out on the out_* side.
interface fp_div_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    // Producer of operands / consumer of results
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    // The divide unit itself
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_div_seq.sv
// Multicycle IEEE-754 divider: radix-2 restoring mantissa division, one
// quotient bit per clock, then a single normalise/round cycle.
// Subnormal inputs are flushed to zero; results below the normal range
// underflow to signed zero.
// Optional feature macro: FP_DIV_RNE_EN selects round-to-nearest-even;
// without it the quotient is truncated (round toward zero).
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic   clk,
    input logic   rst_n,
    fp_div_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int QW    = MAN_W + 3;            // quotient bits, integer bit first
    localparam int RW    = MAN_W + 2;            // remainder holds up to 2*D
    localparam int EW    = EXP_W + 2;            // signed exponent working width
    localparam int CNT_W = $clog2(MAN_W + 4);

    localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX     = EW'((1 << EXP_W) - 1);
    localparam logic [CNT_W-1:0]     CNT_INIT = CNT_W'(MAN_W + 2);
    localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [RW-1:0]          rem_reg, dvs_reg;
    logic [QW-1:0]          quo_reg;
    logic signed [EW-1:0]   exp_reg;
    logic                   sign_reg;
    logic [W-1:0]           result_reg;
    logic [3:0]             flags_reg;

    // ---------------- operand classification ----------------
    logic             sa, sb, sign_ab;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign sa      = bus.a[W-1];
    assign sb      = bus.b[W-1];
    assign ea      = bus.a[W-2:MAN_W];
    assign eb      = bus.b[W-2:MAN_W];
    assign fa      = bus.a[MAN_W-1:0];
    assign fb      = bus.b[MAN_W-1:0];
    assign sign_ab = sa ^ sb;
    // exp == 0 covers both true zero and flushed subnormals
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (ea == '1) && (fa == '0);
    assign b_inf   = (eb == '1) && (fb == '0);
    assign a_nan   = (ea == '1) && (fa != '0);
    assign b_nan   = (eb == '1) && (fb != '0);

    logic             special;
    logic [W-1:0]     sp_result;
    logic [3:0]       sp_flags;

    // Special-case result selection, checked in priority order
    always_comb begin
        special   = 1'b1;
        sp_result = '0;
        sp_flags  = 4'b0000;
        if (a_nan || b_nan) begin
            sp_result = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_result = QNAN;
            sp_flags  = 4'b1000;
        end else if (a_inf) begin
            sp_result = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_zero) begin
            sp_result = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            sp_flags  = 4'b0100;
        end else if (b_inf || a_zero) begin
            sp_result = {sign_ab, {(W-1){1'b0}}};
        end else begin
            special   = 1'b0;
        end
    end

    logic signed [EW-1:0] exp_calc;
    assign exp_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;

    // ---------------- restoring divide step ----------------
    logic          ge;
    logic [RW-1:0] rem_step;
    assign ge       = (rem_reg >= dvs_reg);
    assign rem_step = ge ? (rem_reg - dvs_reg) : rem_reg;

    // ---------------- normalise and round ----------------
    logic                 norm_shift;
    logic [MAN_W:0]       mant_trunc;
    logic [MAN_W+1:0]     mant_round;
    logic                 carry;
    logic [MAN_W-1:0]     frac;
    logic signed [EW-1:0] e_norm, e_final;
    logic [W-1:0]         rnd_result;
    logic [3:0]           rnd_flags;

    // A quotient below 1.0 needs one left shift to bring the hidden bit up
    assign norm_shift = ~quo_reg[QW-1];
    assign mant_trunc = norm_shift ? quo_reg[QW-2:1] : quo_reg[QW-1:2];
    assign e_norm     = exp_reg - $signed({{(EW-1){1'b0}}, norm_shift});

`ifdef FP_DIV_RNE_EN
    logic guard, sticky, round_up;
    assign guard      = norm_shift ? quo_reg[0] : quo_reg[1];
    // A nonzero final remainder means more set bits lie below the quotient
    assign sticky     = (!norm_shift && quo_reg[0]) || (rem_reg != '0);
    assign round_up   = guard && (sticky || mant_trunc[0]);
    assign mant_round = {1'b0, mant_trunc} + (MAN_W+2)'(round_up);
`else
    assign mant_round = {1'b0, mant_trunc};
`endif

    assign carry   = mant_round[MAN_W+1];
    assign frac    = carry ? mant_round[MAN_W:1] : mant_round[MAN_W-1:0];
    assign e_final = e_norm + $signed({{(EW-1){1'b0}}, carry});

    // Range check on the final exponent decides inf / zero / normal
    always_comb begin
        rnd_result = {sign_reg, e_final[EXP_W-1:0], frac};
        rnd_flags  = 4'b0000;
        if (e_final >= EMAX) begin
            rnd_result = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags  = 4'b0010;
        end else if (e_final <= $signed(EW'(0))) begin
            rnd_result = {sign_reg, {(W-1){1'b0}}};
            rnd_flags  = 4'b0001;
        end
    end

    // ---------------- control ----------------
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid) state_next = special ? DONE : DIV;
            DIV:     if (cnt_reg == '0) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: capture on accept, iterate in DIV, commit in ROUND
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            rem_reg    <= '0;
            dvs_reg    <= '0;
            quo_reg    <= '0;
            exp_reg    <= '0;
            sign_reg   <= 1'b0;
            result_reg <= '0;
            flags_reg  <= 4'b0000;
        end else begin
            case (state_reg)
                IDLE: if (bus.in_valid) begin
                    sign_reg <= sign_ab;
                    exp_reg  <= exp_calc;
                    rem_reg  <= {1'b0, 1'b1, fa};
                    dvs_reg  <= {1'b0, 1'b1, fb};
                    quo_reg  <= '0;
                    cnt_reg  <= CNT_INIT;
                    if (special) begin
                        result_reg <= sp_result;
                        flags_reg  <= sp_flags;
                    end
                end
                DIV: begin
                    rem_reg <= rem_step << 1;
                    quo_reg <= {quo_reg[QW-2:0], ge};
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
                ROUND: begin
                    result_reg <= rnd_result;
                    flags_reg  <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.result    = result_reg;
    assign bus.flags     = flags_reg;
endmodule
